// File: rtl/cfg_irq_servicer_if.sv
// Bundles the config-bus, event-FIFO and status signals of the IRQ servicer.
// master: the servicer drives cfg_* requests and the event head.
// slave: the config responder / event consumer side.
interface cfg_irq_servicer_if #(
    parameter int N      = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic              irq;
    logic [ADDR_W-1:0] cfg_addr;
    logic [DATA_W-1:0] cfg_wdata;
    logic              cfg_we;
    logic              cfg_re;
    logic [DATA_W-1:0] cfg_rdata;
    logic              evt_valid;
    logic              evt_ready;
    logic [IDX_W-1:0]  evt_idx;
    logic [1:0]        evt_state;
    logic              busy;
    logic              overflow;
    logic              ovf_clr;

    modport master (
        input  irq, cfg_rdata, evt_ready, ovf_clr,
        output cfg_addr, cfg_wdata, cfg_we, cfg_re,
               evt_valid, evt_idx, evt_state, busy, overflow
    );

    modport slave (
        output irq, cfg_rdata, evt_ready, ovf_clr,
        input  cfg_addr, cfg_wdata, cfg_we, cfg_re,
               evt_valid, evt_idx, evt_state, busy, overflow
    );
endinterface

// File: rtl/cfg_irq_servicer.sv
// Services a level IRQ: reads IRQ_STATUS, reads each flagged peripheral's STATE, queues {idx,state} events, W1C-clears status.
// Latency: 4 + 3*(set bits) cycles per service (3 for a spurious all-zero status); event visible the cycle after its read returns.
// Backpressure: none on the FSM; a push into a full FIFO without a same-cycle pop is dropped and sets sticky overflow.
module cfg_irq_servicer #(
    parameter int N      = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input logic                clk,
    input logic                rst_n,
    cfg_irq_servicer_if.master bus
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int EVT_W = IDX_W + 2;

    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(8'hC0);
    localparam logic [ADDR_W-1:0] STATE_BASE  = ADDR_W'(8'h80);

    typedef enum logic [2:0] {
        IDLE, RD_STAT, WT_STAT, SCAN, RD_ST, WT_ST, CLEAR
    } state_t;

    state_t            state, state_nxt;
    logic [N-1:0]      status_cap, pending;
    logic [IDX_W-1:0]  cur, lowest;

    logic [EVT_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push, pop, full, accept, drop, not_empty;

    // Lowest set bit of the still-pending mask; scanning downward lets the lowest index win.
    always_comb begin
        lowest = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[i]) lowest = IDX_W'(i);
        end
    end

    // State register; reset aborts any service in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state sequencing of the service walk.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.irq) state_nxt = RD_STAT;
            RD_STAT: state_nxt = WT_STAT;
            WT_STAT: state_nxt = SCAN;
            SCAN: begin
                if (pending != '0)         state_nxt = RD_ST;
                else if (status_cap != '0) state_nxt = CLEAR;
                else                       state_nxt = IDLE;
            end
            RD_ST:   state_nxt = WT_ST;
            WT_ST:   state_nxt = SCAN;
            CLEAR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore decode of the config bus strobes from the state register.
    always_comb begin
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;
        bus.cfg_we    = 1'b0;
        bus.cfg_re    = 1'b0;
        bus.busy      = (state != IDLE);
        case (state)
            RD_STAT: begin
                bus.cfg_re   = 1'b1;
                bus.cfg_addr = STATUS_ADDR;
            end
            RD_ST: begin
                bus.cfg_re   = 1'b1;
                bus.cfg_addr = STATE_BASE + ADDR_W'({cur, 2'b00});
            end
            CLEAR: begin
                bus.cfg_we    = 1'b1;
                bus.cfg_addr  = STATUS_ADDR;
                bus.cfg_wdata = DATA_W'(status_cap);
            end
            default: ;
        endcase
    end

    // Captured status, the work-list of bits still to service, and the bit being serviced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_cap <= '0;
            pending    <= '0;
            cur        <= '0;
        end else begin
            case (state)
                WT_STAT: begin
                    status_cap <= bus.cfg_rdata[N-1:0];
                    pending    <= bus.cfg_rdata[N-1:0];
                end
                SCAN:    if (pending != '0) cur <= lowest;
                WT_ST:   pending[cur] <= 1'b0;
                default: ;
            endcase
        end
    end

    assign not_empty = (count != '0);
    assign push      = (state == WT_ST);
    assign pop       = not_empty && bus.evt_ready;
    assign full      = (count == CNT_W'(DEPTH));
    assign accept    = push && (!full || pop);
    assign drop      = push && !accept;

    // Event storage; the read data returned in WT_ST carries the peripheral's power state.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= {cur, bus.cfg_rdata[1:0]};
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the count alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)    rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           bus.overflow <= 1'b0;
        else if (drop)        bus.overflow <= 1'b1;
        else if (bus.ovf_clr) bus.overflow <= 1'b0;
    end

    // Head presentation; zeroed while empty so stale storage never leaks out.
    always_comb begin
        bus.evt_valid = not_empty;
        bus.evt_idx   = not_empty ? mem[rd_ptr][EVT_W-1:2] : '0;
        bus.evt_state = not_empty ? mem[rd_ptr][1:0]       : 2'b00;
    end
endmodule

// File: tb/tb_cfg_irq_servicer.sv
// Randomised plus directed bench for cfg_irq_servicer with a queue-based scoreboard.
// A config responder model answers reads; expected reads, writes and events are queued at stimulus time.
// A negedge monitor pops and compares whenever the DUT strobes the bus or pops an event.
module tb_cfg_irq_servicer;
    localparam int N      = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic clk;
    logic rst_n;

    cfg_irq_servicer_if #(.N(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    cfg_irq_servicer #(.N(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder register contents
    logic [31:0] status_reg;
    logic [31:0] state_mem [N];

    // Scoreboard queues
    logic [7:0]  exp_rd  [$];
    logic [39:0] exp_wr  [$];
    logic [3:0]  exp_evt [$];
    bit          exp_ovf;

    int n_total = 0;
    int n_pass  = 0;
    int n_pops  = 0;
    bit rand_ready = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic unexpected(input string name);
        n_total++;
        $display("FAIL %s: DUT activity with nothing expected", name);
    endtask

    // Registered read responder: data appears the cycle after cfg_re.
    always @(posedge clk) begin
        if (bus.cfg_re) begin
            if (bus.cfg_addr == 8'hC0) bus.cfg_rdata <= status_reg;
            else                       bus.cfg_rdata <= state_mem[bus.cfg_addr[3:2]];
        end
    end

    // Monitor: compare every bus strobe and every event pop against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.cfg_re) begin
                if (exp_rd.size() == 0) unexpected("rd");
                else check("rd_addr", bus.cfg_addr, exp_rd.pop_front());
                check("rd_wdata_zero", bus.cfg_wdata, 0);
            end
            if (bus.cfg_we) begin
                if (exp_wr.size() == 0) unexpected("wr");
                else check("wr_addr_data", {bus.cfg_addr, bus.cfg_wdata}, exp_wr.pop_front());
            end
            if (bus.evt_valid && bus.evt_ready) begin
                n_pops++;
                if (exp_evt.size() == 0) unexpected("evt");
                else check("evt_idx_state", {bus.evt_idx, bus.evt_state}, exp_evt.pop_front());
            end
        end
    end

    // Reference model of one service, derived from the status word alone.
    task automatic expect_service(input logic [31:0] st, input bit force_push, output int exp_busy);
        int ones;
        ones = 0;
        exp_rd.push_back(8'hC0);
        for (int i = 0; i < N; i++) begin
            if (st[i]) begin
                ones++;
                exp_rd.push_back(8'h80 + 8'(4 * i));
                if (force_push || exp_evt.size() < DEPTH)
                    exp_evt.push_back({2'(i), state_mem[i][1:0]});
                else
                    exp_ovf = 1;
            end
        end
        if (ones != 0) exp_wr.push_back({8'hC0, 32'(st[N-1:0])});
        exp_busy = (ones == 0) ? 3 : 4 + 3 * ones;
    endtask

    // Count busy cycles starting just after RD_STAT entry; ends just after IDLE re-entry.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (bus.busy && cnt < 100) begin
            cnt++;
            @(posedge clk); #1;
            if (rand_ready) bus.evt_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic run_service(input logic [31:0] st, input bit keep);
        int eb, cnt;
        status_reg = st;
        expect_service(st, 0, eb);
        if (keep) expect_service(st, 0, eb);
        bus.irq = 1'b1;
        @(posedge clk); #1;
        if (!keep) bus.irq = 1'b0;
        count_busy(cnt);
        check("busy_cycles", cnt, eb);
        if (keep) begin
            @(posedge clk); #1;
            check("irq_restart_busy", bus.busy, 1);
            bus.irq = 1'b0;
            count_busy(cnt);
            check("busy_cycles_restart", cnt, eb);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_evt.size() != 0 && k < 200) begin
            @(posedge clk); #1;
            bus.evt_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            k++;
        end
        @(posedge clk); #1;
        bus.evt_ready = 1'b0;
        check("drain_queue_empty", exp_evt.size(), 0);
        check("evt_valid_after_drain", bus.evt_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  eb, cnt, p0;
        bit  found;
        logic [31:0] st;

        rst_n = 1'b0;
        bus.irq = 1'b0;
        bus.evt_ready = 1'b0;
        bus.ovf_clr = 1'b0;
        bus.cfg_rdata = '0;
        status_reg = '0;
        exp_ovf = 0;
        for (int i = 0; i < N; i++) state_mem[i] = '0;

        #3;
        check("rst_cfg_addr", bus.cfg_addr, 0);
        check("rst_cfg_we_re", {bus.cfg_we, bus.cfg_re}, 0);
        check("rst_cfg_wdata", bus.cfg_wdata, 0);
        check("rst_evt", {bus.evt_valid, bus.evt_idx, bus.evt_state}, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_overflow", bus.overflow, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single-bit service: status 0x4, STATE_2 = 3
        state_mem[2] = 32'h3;
        run_service(32'h4, 0);
        drain();

        // Three bits, ascending order of reads and events
        state_mem[0] = 32'h1; state_mem[1] = 32'h6; state_mem[3] = 32'hFFFF_FFF2;
        run_service(32'hB, 0);
        drain();

        // Only bits above N set: spurious, no state reads, no write
        run_service(32'hF0, 0);
        check("spurious_no_evt", bus.evt_valid, 0);

        // Overflow: 5 events into a 4-deep FIFO with no consumer
        rand_ready = 0;
        bus.evt_ready = 1'b0;
        state_mem[0] = 32'h0; state_mem[1] = 32'h1; state_mem[2] = 32'h2; state_mem[3] = 32'h3;
        run_service(32'hF, 0);
        check("ovf_not_yet", bus.overflow, 0);
        state_mem[0] = 32'h2;
        run_service(32'h1, 0);
        check("ovf_set", bus.overflow, exp_ovf);
        check("ovf_fifo_still_valid", bus.evt_valid, 1);
        bus.ovf_clr = 1'b1;
        @(posedge clk); #1;
        bus.ovf_clr = 1'b0;
        exp_ovf = 0;
        check("ovf_cleared", bus.overflow, exp_ovf);

        // Full FIFO with push and pop in the same cycle
        state_mem[1] = 32'h2;
        status_reg = 32'h2;
        expect_service(32'h2, 1, eb);
        bus.irq = 1'b1;
        @(posedge clk); #1;
        bus.irq = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        bus.evt_ready = 1'b1;
        @(posedge clk); #1;
        bus.evt_ready = 1'b0;
        check("full_pushpop_no_ovf", bus.overflow, 0);
        check("full_pushpop_valid", bus.evt_valid, 1);
        count_busy(cnt);
        check("full_pushpop_busy_tail", cnt, eb - 5);
        p0 = n_pops;
        drain();
        check("full_pushpop_count", n_pops - p0, 4);

        // irq held high across the service restarts it right after IDLE
        state_mem[3] = 32'h1;
        run_service(32'h8, 1);
        drain();

        // Reset during RD_ST aborts with no CLEAR write
        status_reg = 32'h3;
        expect_service(32'h3, 0, eb);
        bus.irq = 1'b1;
        @(posedge clk); #1;
        bus.irq = 1'b0;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (bus.cfg_re && bus.cfg_addr == 8'h80) found = 1;
        end
        check("reached_rd_st", found, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_cfg", {bus.cfg_addr, bus.cfg_wdata, bus.cfg_we, bus.cfg_re}, 0);
        check("midrst_busy_evt", {bus.busy, bus.evt_valid, bus.overflow}, 0);
        exp_rd.delete();
        exp_wr.delete();
        exp_evt.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_idle", bus.busy, 0);

        // Randomised services with a random consumer
        rand_ready = 1;
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < N; i++) state_mem[i] = $urandom;
            st = $urandom;
            if (it % 5 == 0) st = st & 32'hFFFF_FFF0;
            run_service(st, 0);
            drain();
        end
        check("rand_no_ovf", bus.overflow, 0);
        check("rand_rd_queue_empty", exp_rd.size(), 0);
        check("rand_wr_queue_empty", exp_wr.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/cfg_irq_servicer.md
CFG_IRQ_SERVICER -- requirements
Module: cfg_irq_servicer

Interface
REQ-001 Parameters SHALL be: N = 4 (number of peripherals), DATA_W = 32 (config data width), ADDR_W = 8 (config address width), DEPTH = 4 (event FIFO entries, power of 2).
REQ-002 clk  in  1  clock; rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 irq  in  1  level interrupt from the config register block.
REQ-005 cfg_addr  out  ADDR_W  config bus address.
REQ-006 cfg_wdata  out  DATA_W  config write data.
REQ-007 cfg_we  out  1  config write strobe.
REQ-008 cfg_re  out  1  config read strobe.
REQ-009 cfg_rdata  in  DATA_W  read data, registered by the responder; valid the cycle after cfg_re.
REQ-010 evt_valid  out  1  event FIFO not empty.
REQ-011 evt_ready  in  1  consumer pop; pop occurs when evt_valid && evt_ready.
REQ-012 evt_idx  out  max(1,$clog2(N))  peripheral index of the head event.
REQ-013 evt_state  out  2  power state of the head event.
REQ-014 busy  out  1  FSM not in IDLE.
REQ-015 overflow  out  1  sticky event-drop flag.
REQ-016 ovf_clr  in  1  clears overflow.

Function
REQ-017 The FSM SHALL have states IDLE, RD_STAT, WT_STAT, SCAN, RD_ST, WT_ST, CLEAR; cfg_* outputs SHALL be decoded from the state register only (Moore).
REQ-018 IDLE: cfg_we = cfg_re = 0; if irq = 1 at an edge, next state is RD_STAT.
REQ-019 RD_STAT: cfg_re = 1, cfg_addr = 0xC0 (IRQ_STATUS); next state is WT_STAT.
REQ-020 WT_STAT: cfg_re = 0; status_cap and pending SHALL both capture cfg_rdata[N-1:0] at the edge (bits N and above ignored); next state is SCAN.
REQ-021 SCAN: if pending = 0 and status_cap = 0, go to IDLE (spurious, no write); if pending = 0 and status_cap != 0, go to CLEAR; otherwise latch cur = index of the lowest set bit of pending and go to RD_ST.
REQ-022 RD_ST: cfg_re = 1, cfg_addr = 0x80 + 4*cur; next state is WT_ST.
REQ-023 WT_ST: push {cur, cfg_rdata[1:0]} to the FIFO; clear pending[cur]; next state is SCAN.
REQ-024 CLEAR: cfg_we = 1, cfg_addr = 0xC0, cfg_wdata = zero-extended status_cap (write-1-to-clear of captured bits only); next state is IDLE.
REQ-025 cfg_wdata SHALL be 0 in every state other than CLEAR; cfg_addr SHALL be 0 in IDLE, WT_STAT, SCAN and WT_ST.
REQ-026 A single-bit service SHALL take exactly 7 cycles from RD_STAT entry to IDLE re-entry; each additional set bit adds 3 cycles.
REQ-027 FIFO push SHALL be accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle; otherwise the event is dropped and overflow is set.
REQ-028 Simultaneous push and pop SHALL keep the count unchanged; pop when empty SHALL be ignored; pointers SHALL wrap modulo DEPTH.
REQ-029 evt_idx/evt_state SHALL present the head entry; an event is visible at evt_valid the cycle after its WT_ST.
REQ-030 overflow SHALL be set by a drop and cleared by ovf_clr; if both occur in the same cycle, set wins.
REQ-031 The FSM SHALL never stall on FIFO full.
REQ-032 irq still high on IDLE re-entry (a state change arrived during service) SHALL start a new service immediately.
REQ-033 busy = 1 in every state except IDLE.

Reset
REQ-034 While rst_n = 0: state = IDLE; cfg_addr, cfg_wdata, cfg_we, cfg_re = 0; FIFO empty (evt_valid = 0, evt_idx = 0, evt_state = 0); overflow = 0; busy = 0; status_cap, pending, cur = 0.
REQ-035 Reset asserted mid-service SHALL abort the service with no CLEAR write; captured status is lost.

Verification
REQ-036 irq = 1, IRQ_STATUS reads 0x4, STATE_2 reads 0x3 -> read 0xC0, read 0x88, write 0xC0 data 0x4; one event {idx 2, state 3}; 7 busy cycles.
REQ-037 IRQ_STATUS reads 0xB -> STATE reads at 0x80, 0x84, 0x8C in that order; events for idx 0, 1, 3; single write of 0x0000000B.
REQ-038 IRQ_STATUS reads 0xF0 (N = 4) -> no STATE reads, no write, FSM returns to IDLE.
REQ-039 evt_ready = 0, 5 events generated with DEPTH = 4 -> 4 entries retained, 5th dropped, overflow = 1; ovf_clr pulse -> overflow = 0.
REQ-040 FIFO full, push and pop in the same cycle -> count stays 4, no overflow, order preserved.
REQ-041 rst_n asserted during RD_ST -> all outputs 0 immediately; no write to 0xC0 occurs afterward.
